command_arbiter_inex: RTL and testbench

//   Merges 66-bit configuration commands from three independent sources (TSMP agent, local

---
 rtl/command_arbiter_inex.sv | 168 ++++++++++++++++
 tb/tb_command_arbiter_inex.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_arbiter_inex.sv
// Three-source command merger: one FIFO per source, round-robin arbitration onto a single
// registered command channel with downstream hold and an optional inter-command gap.
module command_arbiter_inex #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 3,
   parameter int unsigned GAP        = 0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [65:0] iv_cmd_0,
   input  logic        i_cmd_wr_0,
   output logic        o_cmd_full_0,
   input  logic [65:0] iv_cmd_1,
   input  logic        i_cmd_wr_1,
   output logic        o_cmd_full_1,
   input  logic [65:0] iv_cmd_2,
   input  logic        i_cmd_wr_2,
   output logic        o_cmd_full_2,
   input  logic        i_out_hold,
   output logic [65:0] ov_command,
   output logic        o_command_wr,
   output logic [2:0]  ov_overflow,
   output logic [2:0]  ov_grant
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP + 1) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StGapWait} state_e;

   logic [65:0]     cmd_in [3];
   logic [65:0]     head   [3];
   logic [2:0]      wr_in, wr_acc, pop, eligible, full;
   logic [65:0]     win_cmd;
   logic [1:0]      win, last_q;
   logic            can_grant, take;
   state_e          state_q;
   logic [GapW-1:0] gap_q;
   logic [65:0]     cmd_q;
   logic            wr_q;
   logic [2:0]      grant_q, ovf_q;

   assign cmd_in[0] = iv_cmd_0;
   assign cmd_in[1] = iv_cmd_1;
   assign cmd_in[2] = iv_cmd_2;
   assign wr_in     = {i_cmd_wr_2, i_cmd_wr_1, i_cmd_wr_0};

   for (genvar i = 0; i < 3; i++) begin : g_fifo
      logic [65:0]      mem [FIFO_DEPTH];
      logic [PtrW-1:0]  wptr_q, rptr_q;
      logic [CNT_W-1:0] count_q;

      // Space is judged on the registered count, so a same-cycle pop never frees a slot.
      assign full[i]     = (count_q == CNT_W'(FIFO_DEPTH));
      assign eligible[i] = (count_q != '0);
      assign wr_acc[i]   = wr_in[i] & ~full[i];
      assign head[i]     = mem[rptr_q];

      always_ff @(posedge i_clk) begin
         if (wr_acc[i]) mem[wptr_q] <= cmd_in[i];
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
         end else begin
            if (wr_acc[i]) wptr_q <= wptr_q + PtrW'(1);
            if (pop[i])    rptr_q <= rptr_q + PtrW'(1);
            case ({wr_acc[i], pop[i]})
               2'b10:   count_q <= count_q + CNT_W'(1);
               2'b01:   count_q <= count_q - CNT_W'(1);
               default: ;
            endcase
         end
      end
   end

   assign o_cmd_full_0 = full[0];
   assign o_cmd_full_1 = full[1];
   assign o_cmd_full_2 = full[2];

   // Walk candidates from lowest to highest priority so the last match wins.
   function automatic logic [1:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
      logic [1:0] pick;
      int         c;
      pick = 2'd0;
      for (int k = 3; k >= 1; k--) begin
         c = (int'(last) + k) % 3;
         if (elig[c]) pick = 2'(c);
      end
      return pick;
   endfunction

   assign win = rr_pick(eligible, last_q);

   always_comb begin
      win_cmd = head[0];
      case (win)
         2'd1:    win_cmd = head[1];
         2'd2:    win_cmd = head[2];
         default: win_cmd = head[0];
      endcase
   end

   always_comb begin
      can_grant = 1'b0;
      case (state_q)
         StIdle:    can_grant = 1'b1;
         StIssue:   can_grant = (GAP == 0);
         StGapWait: can_grant = (gap_q == '0);
         default:   can_grant = 1'b0;
      endcase
   end

   assign take = can_grant & (|eligible) & ~i_out_hold;
   assign pop  = take ? (3'b001 << win) : 3'b000;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         gap_q   <= '0;
         last_q  <= 2'd2;
         cmd_q   <= '0;
         wr_q    <= 1'b0;
         grant_q <= '0;
      end else begin
         cmd_q   <= '0;
         wr_q    <= 1'b0;
         grant_q <= '0;
         if (take) begin
            state_q <= StIssue;
            cmd_q   <= win_cmd;
            wr_q    <= 1'b1;
            grant_q <= 3'b001 << win;
            last_q  <= win;
         end else begin
            case (state_q)
               StIssue: begin
                  if (GAP > 0) begin
                     state_q <= StGapWait;
                     gap_q   <= GapW'(GAP - 1);
                  end else begin
                     state_q <= StIdle;
                  end
               end
               StGapWait: begin
                  if (gap_q != '0) gap_q   <= gap_q - GapW'(1);
                  else             state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) ovf_q <= '0;
      else          ovf_q <= wr_in & ~wr_acc;
   end

   assign ov_command   = cmd_q;
   assign o_command_wr = wr_q;
   assign ov_grant     = grant_q;
   assign ov_overflow  = ovf_q;

endmodule

// File: tb/tb_command_arbiter_inex.sv
// Scoreboard bench for command_arbiter_inex: one GAP=0 instance for ordering, hold, overflow
// and reset, plus a GAP=2 instance for issue spacing.
module tb_command_arbiter_inex;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [65:0] cmd_in [3];
   logic [2:0]  wr_in;
   logic        hold;
   logic [2:0]  full;
   logic [65:0] ov_cmd;
   logic        ov_wr;
   logic [2:0]  ovf, gnt;

   logic [65:0] g_cmd, g_zero_cmd;
   logic        g_wr, g_zero;
   logic [2:0]  g_full;
   logic [65:0] g_ov_cmd;
   logic        g_ov_wr;
   logic [2:0]  g_ovf, g_gnt;

   command_arbiter_inex #(.FIFO_DEPTH(4), .CNT_W(3), .GAP(0)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .iv_cmd_0(cmd_in[0]), .i_cmd_wr_0(wr_in[0]), .o_cmd_full_0(full[0]),
      .iv_cmd_1(cmd_in[1]), .i_cmd_wr_1(wr_in[1]), .o_cmd_full_1(full[1]),
      .iv_cmd_2(cmd_in[2]), .i_cmd_wr_2(wr_in[2]), .o_cmd_full_2(full[2]),
      .i_out_hold(hold), .ov_command(ov_cmd), .o_command_wr(ov_wr),
      .ov_overflow(ovf), .ov_grant(gnt)
   );

   command_arbiter_inex #(.FIFO_DEPTH(4), .CNT_W(3), .GAP(2)) dut_gap (
      .i_clk(clk), .i_rst_n(rst_n),
      .iv_cmd_0(g_zero_cmd), .i_cmd_wr_0(g_zero), .o_cmd_full_0(g_full[0]),
      .iv_cmd_1(g_zero_cmd), .i_cmd_wr_1(g_zero), .o_cmd_full_1(g_full[1]),
      .iv_cmd_2(g_cmd), .i_cmd_wr_2(g_wr), .o_cmd_full_2(g_full[2]),
      .i_out_hold(g_zero), .ov_command(g_ov_cmd), .o_command_wr(g_ov_wr),
      .ov_overflow(g_ovf), .ov_grant(g_gnt)
   );

   typedef struct packed {
      logic [2:0]  grant;
      logic [65:0] cmd;
   } exp_t;

   typedef struct packed {
      logic [2:0]      mask;
      logic [1:0]      n;
      logic [2:0][1:0] ord;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   quiet = 1'b0;
   bit   ignore = 1'b0;
   exp_t exp_q[$];
   exp_t exp_g[$];
   int   iss_cyc[$];
   int   g_cyc[$];
   vec_t tbl [6];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic logic [65:0] rnd();
      logic [31:0] a, b;
      logic [1:0]  c;
      a = $urandom;
      b = $urandom;
      c = 2'($urandom_range(3, 0));
      return {c, a, b};
   endfunction

   // Scoreboard for the GAP=0 instance.
   always @(negedge clk) begin
      if (rst_n && !ignore) begin
         if (quiet) begin
            check("quiet_strobe", {65'd0, ov_wr}, 66'd0);
         end else if (ov_wr) begin
            iss_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_strobe: got cmd %h grant %b want none", ov_cmd, gnt);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_cmd", ov_cmd, e.cmd);
               check("sb_grant", {63'd0, gnt}, {63'd0, e.grant});
            end
         end else begin
            check("idle_hygiene", ov_cmd | {63'd0, gnt}, 66'd0);
         end
      end
   end

   // Scoreboard for the GAP=2 instance.
   always @(negedge clk) begin
      if (rst_n && g_ov_wr) begin
         g_cyc.push_back(cyc);
         if (exp_g.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL gap_unexpected: got cmd %h want none", g_ov_cmd);
         end else begin
            exp_t e;
            e = exp_g.pop_front();
            check("gap_cmd", g_ov_cmd, e.cmd);
         end
      end
   end

   task automatic push(input int src, input logic [65:0] d);
      exp_t e;
      e.grant = 3'(1 << src);
      e.cmd   = d;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 after the write edge.
   task automatic apply(input logic [2:0] mask, input logic [65:0] d0, input logic [65:0] d1,
                        input logic [65:0] d2);
      cmd_in[0] = d0;
      cmd_in[1] = d1;
      cmd_in[2] = d2;
      wr_in     = mask;
      @(posedge clk);
      #1;
      wr_in = 3'b000;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check(name, 66'(exp_q.size()), 66'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      iss_cyc.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [65:0] d [3];
      logic [65:0] dd [2][3];
      logic [65:0] h [5];
      logic [65:0] a;
      int          n0;
      bit          seen;

      tbl = '{'{3'b010, 2'd1, 6'b00_00_01},
              '{3'b101, 2'd2, 6'b00_00_10},
              '{3'b111, 2'd3, 6'b00_10_01},
              '{3'b110, 2'd2, 6'b00_10_01},
              '{3'b011, 2'd2, 6'b00_01_00},
              '{3'b100, 2'd1, 6'b00_00_10}};

      for (int s = 0; s < 3; s++) cmd_in[s] = '0;
      wr_in      = 3'b000;
      hold       = 1'b0;
      g_cmd      = '0;
      g_wr       = 1'b0;
      g_zero     = 1'b0;
      g_zero_cmd = '0;
      rst_n      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr", {65'd0, ov_wr}, 66'd0);
      check("rst_cmd", ov_cmd, 66'd0);
      check("rst_grant", {63'd0, gnt}, 66'd0);
      check("rst_ovf", {63'd0, ovf}, 66'd0);
      check("rst_full", {63'd0, full}, 66'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single command latency.
      a = rnd();
      push(0, a);
      apply(3'b001, a, '0, '0);
      check("t1_not_early", {65'd0, ov_wr}, 66'd0);
      @(posedge clk);
      #1;
      check("t1_wr", {65'd0, ov_wr}, 66'd1);
      check("t1_cmd", ov_cmd, a);
      check("t1_grant", {63'd0, gnt}, 66'b001);
      @(posedge clk);
      #1;
      check("t1_single", {65'd0, ov_wr}, 66'd0);
      drain("t1_drain");

      // Round-robin over simultaneous writes, back-to-back.
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < 3; s++) begin
            dd[r][s] = rnd();
            push(s, dd[r][s]);
         end
      apply(3'b111, dd[0][0], dd[0][1], dd[0][2]);
      apply(3'b111, dd[1][0], dd[1][1], dd[1][2]);
      drain("t2_drain");
      check("t2_count", 66'(iss_cyc.size()), 66'd6);
      if (iss_cyc.size() == 6)
         for (int i = 1; i < 6; i++)
            check("t2_consecutive", 66'(iss_cyc[i] - iss_cyc[i-1]), 66'd1);

      // Table of write masks; last winner carries across rows.
      for (int v = 0; v < 6; v++) begin
         for (int s = 0; s < 3; s++) d[s] = rnd();
         for (int j = 0; j < int'(tbl[v].n); j++) push(int'(tbl[v].ord[j]), d[tbl[v].ord[j]]);
         n0 = iss_cyc.size();
         apply(tbl[v].mask, d[0], d[1], d[2]);
         drain("tbl_drain");
         check("tbl_count", 66'(iss_cyc.size() - n0), 66'(tbl[v].n));
      end

      // Fill src1 under hold, overflow on the fifth write.
      hold  = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 5; i++) begin
         h[i] = rnd();
         if (i < 4) push(1, h[i]);
         apply(3'b010, '0, h[i], '0);
         if (i == 2) check("t3_not_full", {65'd0, full[1]}, 66'd0);
         if (i == 3) check("t3_full", {65'd0, full[1]}, 66'd1);
         if (i == 3) check("t3_no_ovf", {63'd0, ovf}, 66'd0);
         if (i == 4) check("t3_ovf", {63'd0, ovf}, 66'b010);
      end
      @(posedge clk);
      #1;
      check("t3_ovf_pulse", {63'd0, ovf}, 66'd0);
      check("t3_still_full", {65'd0, full[1]}, 66'd1);
      quiet = 1'b0;
      hold  = 1'b0;
      n0    = iss_cyc.size();
      drain("t3_drain");
      check("t3_count", 66'(iss_cyc.size() - n0), 66'd4);
      check("t3_empty", {65'd0, full[1]}, 66'd0);

      // Hold with two queued on src0.
      hold  = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 2; i++) begin
         h[i] = rnd();
         push(0, h[i]);
         apply(3'b001, h[i], '0, '0);
      end
      repeat (4) @(posedge clk);
      #1;
      quiet = 1'b0;
      hold  = 1'b0;
      n0    = iss_cyc.size();
      drain("t5_drain");
      check("t5_count", 66'(iss_cyc.size() - n0), 66'd2);

      // GAP=2 instance spacing.
      g_cyc.delete();
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e.grant = 3'b100;
         e.cmd   = rnd();
         exp_g.push_back(e);
         g_cmd = e.cmd;
         g_wr  = 1'b1;
         @(posedge clk);
         #1;
      end
      g_wr = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (exp_g.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check("t4_drain", 66'(exp_g.size()), 66'd0);
      check("t4_count", 66'(g_cyc.size()), 66'd3);
      if (g_cyc.size() == 3)
         for (int i = 1; i < 3; i++)
            check("t4_spacing", 66'(g_cyc[i] - g_cyc[i-1]), 66'd3);

      // Async reset while busy; nothing stale may follow.
      hold   = 1'b1;
      ignore = 1'b1;
      for (int i = 0; i < 3; i++) apply(3'b111, rnd(), rnd(), rnd());
      hold = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (ov_wr) begin
            seen = 1'b1;
            break;
         end
      end
      check("t6_busy", {65'd0, ov_wr}, 66'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_wr", {65'd0, ov_wr}, 66'd0);
      check("t6_rst_cmd", ov_cmd, 66'd0);
      check("t6_rst_grant", {63'd0, gnt}, 66'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      ignore = 1'b0;
      quiet  = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      quiet = 1'b0;
      check("t6_full", {63'd0, full}, 66'd0);
      a = rnd();
      push(2, a);
      apply(3'b100, '0, '0, a);
      drain("t6_fresh");
      if (!seen) $display("t6 note: no strobe before reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
